// File: rtl/ub_sched_addr_gen.sv
// Loop-nest schedule and SRAM address generator for the unified-buffer memtile.
// Optional macro UB_SCHED_GEN_WRAP_EN: restart the nest on exhaustion instead of stopping.
module ub_sched_addr_gen #(
    parameter int unsigned NUM_DIMS = 6,
    parameter int unsigned WIDTH    = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_clk_en,
    input  logic                      i_flush,
    input  logic [3:0]                i_dimensionality,
    input  logic [NUM_DIMS*WIDTH-1:0] i_ranges,
    input  logic [NUM_DIMS*WIDTH-1:0] i_addr_strides,
    input  logic [WIDTH-1:0]          i_addr_start,
    input  logic [NUM_DIMS*WIDTH-1:0] i_sched_strides,
    input  logic [WIDTH-1:0]          i_sched_start,
    output logic                      o_valid_out,
    output logic [WIDTH-1:0]          o_addr_out,
    output logic                      o_done
);

    logic [WIDTH-1:0] r_cyc;
    logic             r_done;
    logic [WIDTH-1:0] r_idx       [NUM_DIMS];
    logic [WIDTH-1:0] r_addr_off  [NUM_DIMS];
    logic [WIDTH-1:0] r_sched_off [NUM_DIMS];
`ifdef UB_SCHED_GEN_WRAP_EN
    logic [WIDTH-1:0] r_sched_base;
`endif

    logic [3:0]       w_dims;
    logic [WIDTH-1:0] w_addr_cur;
    logic [WIDTH-1:0] w_sched_cur;
    logic             w_fire;
    logic             w_exhaust;
    logic [WIDTH-1:0] w_idx_d       [NUM_DIMS];
    logic [WIDTH-1:0] w_addr_off_d  [NUM_DIMS];
    logic [WIDTH-1:0] w_sched_off_d [NUM_DIMS];

    assign w_dims = (i_dimensionality > 4'(NUM_DIMS)) ? 4'(NUM_DIMS) : i_dimensionality;

    // Running address/schedule are the start values plus each dimension's offset accumulator.
    always_comb begin
        w_addr_cur  = i_addr_start;
`ifdef UB_SCHED_GEN_WRAP_EN
        w_sched_cur = i_sched_start + r_sched_base;
`else
        w_sched_cur = i_sched_start;
`endif
        for (int k = 0; k < int'(NUM_DIMS); k++) begin
            w_addr_cur  = w_addr_cur + r_addr_off[k];
            w_sched_cur = w_sched_cur + r_sched_off[k];
        end
    end

    assign w_fire = i_clk_en & ~i_rst & ~i_flush & ~r_done & (w_dims != 4'd0)
                  & (r_cyc >= w_sched_cur);

    assign o_valid_out = w_fire;
    assign o_addr_out  = w_addr_cur;
    assign o_done      = r_done;

    // Odometer step; inactive dimensions pass the carry through untouched.
    always_comb begin
        logic             carry;
        logic [WIDTH-1:0] rng_last;
        carry = w_fire;
        for (int k = 0; k < int'(NUM_DIMS); k++) begin
            w_idx_d[k]       = r_idx[k];
            w_addr_off_d[k]  = r_addr_off[k];
            w_sched_off_d[k] = r_sched_off[k];
            rng_last = (i_ranges[k*WIDTH +: WIDTH] == '0) ? '0
                                                           : i_ranges[k*WIDTH +: WIDTH] - 1'b1;
            if (carry && (k < int'(w_dims))) begin
                if (r_idx[k] == rng_last) begin
                    w_idx_d[k]       = '0;
                    w_addr_off_d[k]  = '0;
                    w_sched_off_d[k] = '0;
                end else begin
                    w_idx_d[k]       = r_idx[k] + 1'b1;
                    w_addr_off_d[k]  = r_addr_off[k] + i_addr_strides[k*WIDTH +: WIDTH];
                    w_sched_off_d[k] = r_sched_off[k] + i_sched_strides[k*WIDTH +: WIDTH];
                    carry            = 1'b0;
                end
            end
        end
        w_exhaust = carry;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cyc       <= '0;
            r_done      <= 1'b0;
            r_idx       <= '{default: '0};
            r_addr_off  <= '{default: '0};
            r_sched_off <= '{default: '0};
`ifdef UB_SCHED_GEN_WRAP_EN
            r_sched_base <= '0;
`endif
        end else if (i_flush) begin
            r_cyc       <= '0;
            r_done      <= 1'b0;
            r_idx       <= '{default: '0};
            r_addr_off  <= '{default: '0};
            r_sched_off <= '{default: '0};
`ifdef UB_SCHED_GEN_WRAP_EN
            r_sched_base <= '0;
`endif
        end else if (i_clk_en) begin
            if (r_cyc != '1) begin
                r_cyc <= r_cyc + 1'b1;
            end
            r_idx       <= w_idx_d;
            r_addr_off  <= w_addr_off_d;
            r_sched_off <= w_sched_off_d;
`ifdef UB_SCHED_GEN_WRAP_EN
            // Indices are already all zero after a full carry; only the time base moves.
            if (w_exhaust) begin
                r_sched_base <= r_cyc + 1'b1;
            end
            r_done <= w_exhaust;
`else
            if (w_exhaust) begin
                r_done <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_ub_sched_addr_gen.sv
// Self-checking bench for ub_sched_addr_gen: directed cases plus randomized configurations
// compared against an iteration-count reference model.
module tb_ub_sched_addr_gen;

    localparam int ND = 6;
    localparam int W  = 16;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_clk_en = 1'b0;
    logic          i_flush = 1'b0;
    logic [3:0]    i_dimensionality;
    logic [ND*W-1:0] i_ranges, i_addr_strides, i_sched_strides;
    logic [W-1:0]  i_addr_start, i_sched_start;
    logic          o_valid_out;
    logic [W-1:0]  o_addr_out;
    logic          o_done;

    logic [3:0]    cfg_dims;
    logic [W-1:0]  cfg_ranges [ND];
    logic [W-1:0]  cfg_astr   [ND];
    logic [W-1:0]  cfg_sstr   [ND];
    logic [W-1:0]  cfg_astart, cfg_sstart;

    int n_checks = 0;
    int n_pass   = 0;
    int t        = 0;
    int obs_t [$];
    int obs_a [$];

    // Reference model state: elapsed enabled cycles, iterations issued, done, time base.
    logic [W-1:0] m_cyc;
    int           m_n;
    logic         m_done;
    logic [W-1:0] m_base;

    ub_sched_addr_gen #(.NUM_DIMS(ND), .WIDTH(W)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_clk_en         (i_clk_en),
        .i_flush          (i_flush),
        .i_dimensionality (i_dimensionality),
        .i_ranges         (i_ranges),
        .i_addr_strides   (i_addr_strides),
        .i_addr_start     (i_addr_start),
        .i_sched_strides  (i_sched_strides),
        .i_sched_start    (i_sched_start),
        .o_valid_out      (o_valid_out),
        .o_addr_out       (o_addr_out),
        .o_done           (o_done)
    );

    always #5 i_clk = ~i_clk;

    always_comb begin
        i_dimensionality = cfg_dims;
        i_addr_start     = cfg_astart;
        i_sched_start    = cfg_sstart;
        i_ranges         = '0;
        i_addr_strides   = '0;
        i_sched_strides  = '0;
        for (int k = 0; k < ND; k++) begin
            i_ranges[k*W +: W]        = cfg_ranges[k];
            i_addr_strides[k*W +: W]  = cfg_astr[k];
            i_sched_strides[k*W +: W] = cfg_sstr[k];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0d)", tag, got, exp, t);
    endtask

    function automatic int dims_eff();
        return (cfg_dims > 4'(ND)) ? ND : int'(cfg_dims);
    endfunction

    function automatic int reff(input int k);
        return (cfg_ranges[k] == 0) ? 1 : int'(cfg_ranges[k]);
    endfunction

    function automatic int total_iters();
        int p = 1;
        for (int k = 0; k < dims_eff(); k++) p = p * reff(k);
        return p;
    endfunction

    // Decompose iteration number n into mixed-radix indices and weight them by the strides.
    function automatic logic [W-1:0] iter_val(input int n, input logic [W-1:0] start,
                                              input bit use_sched);
        logic [W-1:0] s = start;
        int rem = n;
        for (int k = 0; k < dims_eff(); k++) begin
            int i = rem % reff(k);
            rem = rem / reff(k);
            s = s + W'(i * int'(use_sched ? cfg_sstr[k] : cfg_astr[k]));
        end
        return s;
    endfunction

    function automatic logic model_valid(input logic en, input logic fl);
        return en && !fl && !m_done && (cfg_dims != 0)
            && (m_cyc >= iter_val(m_n, cfg_sstart + m_base, 1'b1));
    endfunction

    task automatic model_reset();
        m_cyc = '0; m_n = 0; m_done = 1'b0; m_base = '0;
    endtask

    task automatic model_step(input logic en, input logic fl, input logic v);
        if (fl) model_reset();
        else if (en) begin
`ifdef UB_SCHED_GEN_WRAP_EN
            m_done = 1'b0;
`endif
            if (v) begin
                m_n++;
                if (m_n == total_iters()) begin
                    m_done = 1'b1;
`ifdef UB_SCHED_GEN_WRAP_EN
                    m_n = 0;
                    m_base = m_cyc + 1'b1;
`endif
                end
            end
            if (m_cyc != 16'hFFFF) m_cyc = m_cyc + 1'b1;
        end
    endtask

    // One clock cycle: inputs applied just after the edge, outputs checked mid-cycle.
    task automatic cycle(input logic en, input logic fl);
        logic ev;
        i_clk_en = en;
        i_flush  = fl;
        #4;
        ev = model_valid(en, fl);
        check("valid", 32'(o_valid_out), 32'(ev));
        check("done", 32'(o_done), 32'(m_done));
        if (ev) check("addr", 32'(o_addr_out), 32'(iter_val(m_n, cfg_astart, 1'b0)));
        if (o_valid_out) begin
            obs_t.push_back(t);
            obs_a.push_back(int'(o_addr_out));
        end
        model_step(en, fl, ev);
        t++;
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_reset_state();
        check("rst_valid", 32'(o_valid_out), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_addr", 32'(o_addr_out), 32'(cfg_astart));
    endtask

    task automatic do_reset();
        i_rst = 1'b1; i_clk_en = 1'b1; i_flush = 1'b0;
        model_reset();
        #1;
        check_reset_state();
        @(posedge i_clk);
        #1;
        check_reset_state();
        i_rst = 1'b0;
        t = 0;
        obs_t.delete();
        obs_a.delete();
    endtask

    task automatic clear_cfg();
        cfg_dims = 4'd1; cfg_astart = '0; cfg_sstart = '0;
        for (int k = 0; k < ND; k++) begin
            cfg_ranges[k] = '0; cfg_astr[k] = '0; cfg_sstr[k] = '0;
        end
    endtask

    task automatic check_fires(input string tag, input int et[8], input int ea[8], input int n);
        check({tag, "_count"}, 32'(obs_t.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (i < obs_t.size()) begin
                check({tag, "_time"}, 32'(obs_t[i]), 32'(et[i]));
                check({tag, "_addr"}, 32'(obs_a[i]), 32'(ea[i]));
            end
        end
    endtask

    task automatic cfg_2d();
        clear_cfg();
        cfg_dims = 4'd2;
        cfg_ranges[0] = 16'd3; cfg_astr[0] = 16'd1;  cfg_sstr[0] = 16'd2;
        cfg_ranges[1] = 16'd2; cfg_astr[1] = 16'd10; cfg_sstr[1] = 16'd10;
    endtask

    initial begin
        clear_cfg();
        @(posedge i_clk);
        #1;

        // 1-D: fires at 3..6, done from 7.
        cfg_ranges[0] = 16'd4; cfg_astr[0] = 16'd1; cfg_sstr[0] = 16'd1;
        cfg_astart = 16'd61; cfg_sstart = 16'd3;
        do_reset();
        repeat (12) cycle(1'b1, 1'b0);
        check_fires("1d", '{3, 4, 5, 6, 0, 0, 0, 0}, '{61, 62, 63, 64, 0, 0, 0, 0}, 4);

        // Same nest with clk_en low in cycles 2-4.
        do_reset();
        for (int i = 0; i < 14; i++) cycle(!(i >= 2 && i <= 4), 1'b0);
        check_fires("1d_en", '{6, 7, 8, 9, 0, 0, 0, 0}, '{61, 62, 63, 64, 0, 0, 0, 0}, 4);

        // 2-D nest.
        cfg_2d();
        do_reset();
        repeat (20) cycle(1'b1, 1'b0);
        check_fires("2d", '{0, 2, 4, 10, 12, 14, 0, 0}, '{0, 1, 2, 10, 11, 12, 0, 0}, 6);

        // 2-D with reset during cycles 5..7, then a full restart.
        do_reset();
        repeat (5) cycle(1'b1, 1'b0);
        i_rst = 1'b1;
        model_reset();
        repeat (3) begin
            #4;
            check_reset_state();
            @(posedge i_clk);
            #1;
        end
        i_rst = 1'b0;
        t = 0;
        obs_t.delete();
        obs_a.delete();
        repeat (20) cycle(1'b1, 1'b0);
        check_fires("2d_rst", '{0, 2, 4, 10, 12, 14, 0, 0}, '{0, 1, 2, 10, 11, 12, 0, 0}, 6);

        // Late schedule: every iteration due at time 0.
        clear_cfg();
        cfg_ranges[0] = 16'd3; cfg_astr[0] = 16'd5;
        do_reset();
        repeat (6) cycle(1'b1, 1'b0);
`ifndef UB_SCHED_GEN_WRAP_EN
        check_fires("late", '{0, 1, 2, 0, 0, 0, 0, 0}, '{0, 5, 10, 0, 0, 0, 0, 0}, 3);
`endif

`ifdef UB_SCHED_GEN_WRAP_EN
        clear_cfg();
        cfg_ranges[0] = 16'd2; cfg_astr[0] = 16'd1; cfg_sstr[0] = 16'd1;
        do_reset();
        repeat (5) cycle(1'b1, 1'b0);
        check_fires("wrap", '{0, 1, 3, 4, 0, 0, 0, 0}, '{0, 1, 0, 1, 0, 0, 0, 0}, 4);
`endif

        // Randomized configurations with random enable gaps and occasional flushes.
        for (int c = 0; c < 24; c++) begin
            clear_cfg();
            cfg_dims   = 4'($urandom_range(0, 8));
            cfg_astart = 16'($urandom);
            cfg_sstart = 16'($urandom_range(0, 20));
            for (int k = 0; k < ND; k++) begin
                cfg_ranges[k] = 16'($urandom_range(0, 3));
                cfg_astr[k]   = 16'($urandom);
                cfg_sstr[k]   = 16'($urandom_range(0, 4));
            end
            do_reset();
            repeat (250) cycle($urandom_range(0, 3) != 0, $urandom_range(0, 59) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ub_sched_addr_gen.md
# ub_sched_addr_gen

Loop-nest schedule and address generator for the unified-buffer memtile, driving the SRAM port from the same configuration fields the memtile wrapper ties off: dimensionality, ranges, address strides and starting address, schedule strides and starting time. A free-running cycle counter is compared against the schedule of the current loop iteration. On a match, the block pulses `valid_out` with the iteration's SRAM address and advances the nest. Two instances are used per delay line: one read-side and one write-side. Offsetting the write starting address from the read starting address sets the delay length.

## Interface
- NUM_DIMS, 6, maximum loop-nest depth
- WIDTH, 16, width of addresses, strides, ranges, schedule times and cycle counter
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- clk_en  in  1  global step enable; when low, all state holds
- flush  in  1  synchronous restart to reset state; has priority over clk_en
- dimensionality  in  4  active loop count, 1..NUM_DIMS; 0 disables the generator; values above NUM_DIMS clamp to NUM_DIMS
- ranges  in  NUM_DIMS×WIDTH  iteration count per dimension; 0 is treated as 1
- addr_strides  in  NUM_DIMS×WIDTH  address increment per dimension
- addr_start  in  WIDTH  address of iteration (0,…,0)
- sched_strides  in  NUM_DIMS×WIDTH  schedule-time increment per dimension
- sched_start  in  WIDTH  schedule time of iteration (0,…,0)
- valid_out  out  1  access fires this cycle
- addr_out  out  WIDTH  SRAM address for the current iteration
- done  out  1  loop nest exhausted

## Operation
- State: cycle counter `cyc`; per-dimension index `idx[i]`; running address `addr_cur`; running schedule `sched_cur`; `done` flag.
- Meaning of the running values:
  - `addr_cur` = addr_start + Σ idx[i]·addr_strides[i]
  - `sched_cur` = sched_start + Σ idx[i]·sched_strides[i]
  - All sums are modulo 2^WIDTH.
  - Maintain them incrementally with per-dimension offset accumulators; no multipliers.
- `valid_out` = clk_en & ~flush & ~done & (dimensionality≠0) & (cyc ≥ sched_cur), unsigned compare.
  - Late fires are therefore allowed: at most one fire per cycle, no event is dropped.
- `addr_out` = addr_cur, combinational from registers, and is meaningful only while `valid_out` is high.
- On a fire, the nest steps as an odometer:
  - idx[0] increments.
  - When idx[k] = ranges[k]−1, idx[k] clears and idx[k+1] increments.
  - The carry chain is evaluated in a single cycle.
  - Carry out of dimension dimensionality−1 marks the nest exhausted.
- `cyc` increments on every clk_en cycle and saturates at 2^WIDTH−1.
- Configuration inputs are sampled continuously. They must be held static between reset/flush and done; changing them mid-run is undefined.

## Timing
- Reset (rst high, asynchronous): `cyc`, all `idx`, and `done` go to 0; `addr_cur` ← addr_start; `sched_cur` ← sched_start.
  - `valid_out` 0, `done` 0, `addr_out` = addr_start.
  - Reset asserted mid-run aborts immediately; no further pulses.
- Flush: same end state as reset, applied at the next clk edge. In a cycle where flush is high, `valid_out` is 0.
- Latency:
  - With sched_start = S and clk_en held high from reset release, the first `valid_out` occurs in the cycle where `cyc` = S, i.e. S cycles after the first enabled edge.
  - Iteration n fires in the cycle where `cyc` = sched(n).
- Inner-loop wrap and outer increment happen on the same edge as the fire. The next iteration's address is visible in the following cycle.
- Final fire:
  - `done` rises at the next edge and stays high.
  - With WRAP compiled in, `done` instead pulses high for one cycle.
- clk_en low: `cyc`, indices, and accumulators hold; `valid_out` 0.

## Configuration
- `UB_SCHED_GEN_WRAP_EN`
  - Defined: on exhaustion, indices and accumulators reload to start values. `cyc` continues, so the schedule repeats offset by the current `cyc`. `done` is a one-cycle pulse; `valid_out` resumes once `cyc` ≥ the new `sched_cur`, where the new `sched_cur` = sched_start + (`cyc` at exhaustion + 1).
  - Undefined: the generator stops with `done` sticky high until rst or flush.

## Test plan
- 1-D, ranges={4}, addr_strides={1}, sched_strides={1}, addr_start=61, sched_start=3 -> valid_out high in cycles 3..6, addr_out 61,62,63,64; done high from cycle 7.
- 2-D, ranges={3,2}, addr_strides={1,10}, sched_strides={2,10}, starts 0 -> fires at cycles 0,2,4,10,12,14 with addresses 0,1,2,10,11,12.
- Late schedule: sched_strides={0}, ranges={3}, sched_start=0 -> valid_out high three consecutive cycles (0,1,2), then done.
- clk_en low for cycles 2–4 during the 1-D case -> fires shift by 3 cycles; no skipped or duplicated address.
- Reset asserted at cycle 5 of the 2-D case, released at cycle 8 -> valid_out 0 and addr_out=0 during reset; sequence restarts from iteration (0,0).
- With UB_SCHED_GEN_WRAP_EN, ranges={2}, sched_strides={1}, sched_start=0 -> fires 0,1; done pulse at 2; fires again at 3,4.
